// File: rtl/conv_ctrl_pkg.sv
// Shared constants for the convolution control blocks:
// FSM state encoding and stride codes.
package conv_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic STRIDE_1 = 1'b0;
  localparam logic STRIDE_2 = 1'b1;

endpackage

// File: rtl/stride_sched_ctrl.sv
// Frame scanner that decimates a pixel stream by 1x1 or 2x2 stride.
// Optional perf counters: define STRIDE_SCHED_PERF_EN.
module stride_sched_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = 299,
  parameter int IMG_HEIGHT = 299,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stride_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef STRIDE_SCHED_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       drop_cnt
`endif
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_END  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_END2 = CW'(((IMG_WIDTH - 1) / 2) * 2);
  localparam logic [RW-1:0] ROW_END2 = RW'(((IMG_HEIGHT - 1) / 2) * 2);

  function automatic logic keep_px(
    input logic          s,
    input logic [RW-1:0] r,
    input logic [CW-1:0] c
  );
    return (s == STRIDE_1) || (!r[0] && !c[0]);
  endfunction

  logic [1:0]    state;
  logic          stride_q;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          xfer;
  logic          kept;
  logic          last_px;
  logic          frame_end;

  assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
  assign xfer      = in_valid && in_ready;
  assign kept      = keep_px(stride_q, row, col);
  assign frame_end = (row == ROW_END) && (col == COL_END);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Final kept pixel sits on the even floor of the last row/col in 2x2 mode.
  always_comb begin
    last_px = 1'b0;
    if (stride_q == STRIDE_1)
      last_px = frame_end;
    else
      last_px = (row == ROW_END2) && (col == COL_END2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      stride_q <= STRIDE_1;
      row      <= '0;
      col      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            stride_q <= stride_sel;
            row      <= '0;
            col      <= '0;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (col == COL_END) begin
              col <= '0;
              row <= (row == ROW_END) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (frame_end)
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!out_valid || (out_ready && out_last))
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (xfer && kept) begin
      out_valid <= 1'b1;
      out_last  <= last_px;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

`ifdef STRIDE_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (xfer && !kept && drop_cnt != '1)
        drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule
